// File: rtl/csr_unit_mhpm.sv
// Machine-mode CSR unit for the RV32 core with a configurable HPM counter bank.
// Define MTVEC_VECTORED_EN to make mtvec[1:0] writable and enable vectored interrupts.
module csr_unit_mhpm #(
  parameter int unsigned NUM_HPM     = 4,
  parameter int unsigned HPM_EVT_W   = 8,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 wr_en_in,
  input  logic [11:0]          csr_addr_in,
  input  logic [2:0]           csr_op_in,
  input  logic [4:0]           csr_uimm_in,
  input  logic [31:0]          csr_data_in,
  input  logic [31:0]          pc_in,
  input  logic                 eirq_in,
  input  logic                 tirq_in,
  input  logic                 sirq_in,
  input  logic [63:0]          rc_in,
  input  logic                 trap_take_in,
  input  logic                 i_or_e_in,
  input  logic [3:0]           cause_in,
  input  logic                 mret_in,
  input  logic                 instret_inc_in,
  input  logic [HPM_EVT_W-1:0] hpm_evt_in,
  output logic [31:0]          csr_data_out,
  output logic                 illegal_out,
  output logic [31:0]          epc_out,
  output logic [31:0]          trap_address_out,
  output logic                 mie_out,
  output logic                 meie_out,
  output logic                 mtie_out,
  output logic                 msie_out,
  output logic                 meip_out,
  output logic                 mtip_out,
  output logic                 msip_out
);
  localparam int unsigned HPM_N    = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_TIME     = 12'hC01;
  localparam logic [11:0] A_TIMEH    = 12'hC81;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;

  logic        mstatus_mie, mstatus_mpie;
  logic        meie, mtie, msie, meip, mtip, msip;
  logic [29:0] mtvec_base;
  logic [1:0]  mtvec_mode;
  logic [31:0] mscratch, mcause;
  logic [29:0] mepc;
  logic [63:0] mcycle, minstret;
  logic [63:0] hpm_cnt [HPM_N];
  logic [31:0] hpm_evt [HPM_N];
  logic [HPM_N-1:0] hpm_hit;

  logic [31:0] wd, rdata, nv;
  logic [63:0] cnt_sel;
  logic        legal, read_only, do_write, csr_we;
  logic [4:0]  cidx;
  logic        unused_pc;

  assign unused_pc = ^pc_in[1:0];
  assign cidx      = csr_addr_in[4:0];
  assign wd        = csr_op_in[2] ? {27'b0, csr_uimm_in} : csr_data_in;
  // Set/clear with a zero mask is a pure read and must not trip read-only checks.
  assign do_write  = (csr_op_in[1:0] == 2'b01) | (csr_op_in[1] & (wd != '0));

  always_comb begin
    rdata     = '0;
    cnt_sel   = '0;
    legal     = 1'b1;
    read_only = (csr_addr_in[11:10] == 2'b11) || (csr_addr_in == A_MISA);
    case (csr_addr_in)
      A_MSTATUS:  rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      A_MISA:     rdata = MISA_VAL;
      A_MIE:      rdata = {20'b0, meie, 3'b0, mtie, 3'b0, msie, 3'b0};
      A_MIP:      rdata = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
      A_MTVEC:    rdata = {mtvec_base, mtvec_mode};
      A_MSCRATCH: rdata = mscratch;
      A_MEPC:     rdata = {mepc, 2'b00};
      A_MCAUSE:   rdata = mcause;
      A_MHARTID:  rdata = HART_ID;
      A_TIME:     rdata = rc_in[31:0];
      A_TIMEH:    rdata = rc_in[63:32];
      default: begin
        if (csr_addr_in[11:8] == 4'hB && csr_addr_in[6:5] == 2'b00 && cidx != 5'd1) begin
          case (cidx)
            5'd0: cnt_sel = mcycle;
            5'd2: cnt_sel = minstret;
            default: begin
              for (int unsigned i = 0; i < NUM_HPM; i++)
                if ({27'b0, cidx} == i + 32'd3) cnt_sel = hpm_cnt[i];
            end
          endcase
          rdata = csr_addr_in[7] ? cnt_sel[63:32] : cnt_sel[31:0];
        end else if (csr_addr_in[11:5] == 7'b0011_001 && cidx >= 5'd3) begin
          for (int unsigned i = 0; i < NUM_HPM; i++)
            if ({27'b0, cidx} == i + 32'd3) rdata = hpm_evt[i];
        end else begin
          legal = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    case (csr_op_in[1:0])
      2'b10:   nv = rdata | wd;
      2'b11:   nv = rdata & ~wd;
      default: nv = wd;
    endcase
  end

  always_comb begin
    hpm_hit = '0;
    for (int unsigned i = 0; i < NUM_HPM; i++)
      for (int unsigned j = 0; j < HPM_EVT_W; j++)
        if (hpm_evt[i] == j && hpm_evt_in[j]) hpm_hit[i] = 1'b1;
  end

  assign illegal_out = wr_en_in & (~legal | (read_only & do_write));
  assign csr_we      = wr_en_in & ~illegal_out & do_write & ~trap_take_in & ~mret_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      {meie, mtie, msie, meip, mtip, msip} <= '0;
      mtvec_base   <= RESET_MTVEC[31:2];
`ifdef MTVEC_VECTORED_EN
      mtvec_mode   <= (RESET_MTVEC[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
      mscratch     <= '0;
      mcause       <= '0;
      mepc         <= '0;
      mcycle       <= '0;
      minstret     <= '0;
      for (int unsigned i = 0; i < HPM_N; i++) begin
        hpm_cnt[i] <= '0;
        hpm_evt[i] <= '0;
      end
    end else begin
      meip <= eirq_in;
      mtip <= tirq_in;
      msip <= sirq_in;

      if (trap_take_in) begin
        mepc         <= pc_in[31:2];
        mcause       <= {i_or_e_in, 27'b0, cause_in};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_in) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr_in)
          A_MSTATUS: begin
            mstatus_mie  <= nv[3];
            mstatus_mpie <= nv[7];
          end
          A_MIE: begin
            meie <= nv[11];
            mtie <= nv[7];
            msie <= nv[3];
          end
          A_MTVEC: begin
            mtvec_base <= nv[31:2];
`ifdef MTVEC_VECTORED_EN
            mtvec_mode <= (nv[1:0] == 2'b01) ? 2'b01 : 2'b00;
`endif
          end
          A_MSCRATCH: mscratch <= nv;
          A_MEPC:     mepc     <= nv[31:2];
          A_MCAUSE:   mcause   <= nv;
          default: ;
        endcase
      end

      // A half-write replaces that half and skips this cycle's increment.
      if (csr_we && csr_addr_in == A_MCYCLE)        mcycle <= {mcycle[63:32], nv};
      else if (csr_we && csr_addr_in == A_MCYCLEH)  mcycle <= {nv, mcycle[31:0]};
      else                                          mcycle <= mcycle + 64'd1;

      if (csr_we && csr_addr_in == A_MINSTR)        minstret <= {minstret[63:32], nv};
      else if (csr_we && csr_addr_in == A_MINSTRH)  minstret <= {nv, minstret[31:0]};
      else if (instret_inc_in)                      minstret <= minstret + 64'd1;

      for (int unsigned i = 0; i < NUM_HPM; i++) begin
        if (csr_we && csr_addr_in == 12'(32'hB03 + i))
          hpm_cnt[i] <= {hpm_cnt[i][63:32], nv};
        else if (csr_we && csr_addr_in == 12'(32'hB83 + i))
          hpm_cnt[i] <= {nv, hpm_cnt[i][31:0]};
        else if (hpm_hit[i])
          hpm_cnt[i] <= hpm_cnt[i] + 64'd1;
        if (csr_we && csr_addr_in == 12'(32'h323 + i))
          hpm_evt[i] <= nv;
      end
    end
  end

`ifndef MTVEC_VECTORED_EN
  assign mtvec_mode = 2'b00;
`endif

`ifdef MTVEC_VECTORED_EN
  assign trap_address_out = (mtvec_mode == 2'b01 && i_or_e_in)
                          ? {mtvec_base, 2'b00} + {26'b0, cause_in, 2'b00}
                          : {mtvec_base, 2'b00};
`else
  assign trap_address_out = {mtvec_base, 2'b00};
`endif

  assign csr_data_out = rdata;
  assign epc_out      = {mepc, 2'b00};
  assign mie_out      = mstatus_mie;
  assign meie_out     = meie;
  assign mtie_out     = mtie;
  assign msie_out     = msie;
  assign meip_out     = meip;
  assign mtip_out     = mtip;
  assign msip_out     = msip;
endmodule

// File: tb/tb_csr_unit_mhpm.sv
// Self-checking bench for csr_unit_mhpm: directed scenarios then randomized
// traffic compared against a behavioural CSR model.
module tb_csr_unit_mhpm;
  localparam int unsigned NUM_HPM  = 4;
  localparam int unsigned EVT_W    = 8;
  localparam logic [31:0] RST_TVEC = 32'h0000_1003;
  localparam logic [31:0] HARTID   = 32'd5;

  logic clk = 1'b0;
  logic rst, wr_en, eirq, tirq, sirq, trap, ioe, mret, inst;
  logic [11:0] addr;
  logic [2:0] op;
  logic [4:0] uimm;
  logic [31:0] data, pc;
  logic [63:0] rc;
  logic [3:0] cause;
  logic [EVT_W-1:0] evt;
  logic [31:0] rdata, epc, taddr;
  logic illegal, mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o;

  csr_unit_mhpm #(.NUM_HPM(NUM_HPM), .HPM_EVT_W(EVT_W), .RESET_MTVEC(RST_TVEC), .HART_ID(HARTID)) dut (
    .clk_in(clk), .rst_in(rst), .wr_en_in(wr_en), .csr_addr_in(addr), .csr_op_in(op),
    .csr_uimm_in(uimm), .csr_data_in(data), .pc_in(pc), .eirq_in(eirq), .tirq_in(tirq),
    .sirq_in(sirq), .rc_in(rc), .trap_take_in(trap), .i_or_e_in(ioe), .cause_in(cause),
    .mret_in(mret), .instret_inc_in(inst), .hpm_evt_in(evt), .csr_data_out(rdata),
    .illegal_out(illegal), .epc_out(epc), .trap_address_out(taddr), .mie_out(mie_o),
    .meie_out(meie_o), .mtie_out(mtie_o), .msie_out(msie_o), .meip_out(meip_o),
    .mtip_out(mtip_o), .msip_out(msip_o));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause;
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hc [NUM_HPM];
  logic [31:0] m_he [NUM_HPM];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tvec_legal(input logic [31:0] v);
`ifdef MTVEC_VECTORED_EN
    return (v[1:0] == 2'b01) ? v : {v[31:2], 2'b00};
`else
    return {v[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] m_trap_addr();
    logic [31:0] base;
    base = {m_tvec[31:2], 2'b00};
`ifdef MTVEC_VECTORED_EN
    if (m_tvec[1:0] == 2'b01 && ioe) return base + 32'(cause) * 32'd4;
`endif
    return base;
  endfunction

  function automatic logic [63:0] m_cnt(input int n);
    if (n == 0) return m_cyc;
    if (n == 2) return m_ins;
    if (n >= 3 && n - 3 < int'(NUM_HPM)) return m_hc[n-3];
    return 64'd0;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_ip = 0; m_tvec = tvec_legal(RST_TVEC);
    m_scratch = 0; m_epc = 0; m_cause = 0; m_cyc = 0; m_ins = 0;
    for (int i = 0; i < int'(NUM_HPM); i++) begin m_hc[i] = 0; m_he[i] = 0; end
  endtask

  task automatic m_read(input logic [11:0] a, output bit lg, output bit ro, output logic [31:0] d);
    int n;
    lg = 1; d = 0;
    ro = (a >= 12'hC00) || (a == 12'h301);
    case (a)
      12'h300: d = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: d = 32'h4000_0100;
      12'h304: d = m_ie;
      12'h305: d = m_tvec;
      12'h340: d = m_scratch;
      12'h341: d = m_epc;
      12'h342: d = m_cause;
      12'h344: d = m_ip;
      12'hF14: d = HARTID;
      12'hC01: d = rc[31:0];
      12'hC81: d = rc[63:32];
      default: begin
        if (a >= 12'hB00 && a <= 12'hB1F && a != 12'hB01) begin
          d = m_cnt(int'(a) - 'hB00) [31:0];
        end else if (a >= 12'hB80 && a <= 12'hB9F && a != 12'hB81) begin
          d = m_cnt(int'(a) - 'hB80) [63:32];
        end else if (a >= 12'h323 && a <= 12'h33F) begin
          n = int'(a) - 'h323;
          if (n < int'(NUM_HPM)) d = m_he[n];
        end else begin
          lg = 0; ro = 0;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] wdata();
    return op[2] ? {27'b0, uimm} : data;
  endfunction

  function automatic bit writes();
    return (op[1:0] == 2'b01) || (op[1:0] >= 2'b10 && wdata() != 0);
  endfunction

  task automatic check_all();
    bit lg, ro;
    logic [31:0] d;
    m_read(addr, lg, ro, d);
    chk("rdata", rdata, d);
    chk("illegal", {31'b0, illegal}, {31'b0, wr_en && (!lg || (ro && writes()))});
    chk("epc", epc, m_epc);
    chk("trap_addr", taddr, m_trap_addr());
    chk("irq_bits", {25'b0, mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o},
        {25'b0, m_mie, m_ie[11], m_ie[7], m_ie[3], m_ip[11], m_ip[7], m_ip[3]});
  endtask

  task automatic step_model();
    bit lg, ro, we, hi;
    logic [31:0] old, nv, wd;
    logic [63:0] ncyc, nins;
    logic [63:0] nhc [NUM_HPM];
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    m_read(addr, lg, ro, old);
    wd = wdata();
    nv = (op[1:0] == 2'b01) ? wd : (op[1:0] == 2'b10) ? (old | wd) : (old & ~wd);
    we = wr_en && lg && !(ro && writes()) && writes() && !trap && !mret;
    ncyc = m_cyc + 1;
    nins = m_ins + (inst ? 64'd1 : 64'd0);
    for (int i = 0; i < int'(NUM_HPM); i++)
      nhc[i] = m_hc[i] + ((m_he[i] < EVT_W && ((evt >> m_he[i]) & 1) != 0) ? 64'd1 : 64'd0);
    if (we && ((addr >= 12'hB00 && addr <= 12'hB1F) || (addr >= 12'hB80 && addr <= 12'hB9F))) begin
      hi = addr >= 12'hB80;
      n = int'(addr) - (hi ? 'hB80 : 'hB00);
      if (n == 0) ncyc = hi ? {nv, m_cyc[31:0]} : {m_cyc[63:32], nv};
      else if (n == 2) nins = hi ? {nv, m_ins[31:0]} : {m_ins[63:32], nv};
      else if (n >= 3 && n - 3 < int'(NUM_HPM))
        nhc[n-3] = hi ? {nv, m_hc[n-3][31:0]} : {m_hc[n-3][63:32], nv};
    end
    if (we && addr >= 12'h323 && addr <= 12'h33F) begin
      n = int'(addr) - 'h323;
      if (n < int'(NUM_HPM)) m_he[n] = nv;
    end
    if (we) begin
      case (addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_ie = nv & 32'h888;
        12'h305: m_tvec = tvec_legal(nv);
        12'h340: m_scratch = nv;
        12'h341: m_epc = {nv[31:2], 2'b00};
        12'h342: m_cause = nv;
        default: ;
      endcase
    end
    if (trap) begin
      m_epc = {pc[31:2], 2'b00};
      m_cause = {ioe, 27'b0, cause};
      m_mpie = m_mie;
      m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end
    m_ip = (32'(eirq) << 11) | (32'(tirq) << 7) | (32'(sirq) << 3);
    m_cyc = ncyc;
    m_ins = nins;
    for (int i = 0; i < int'(NUM_HPM); i++) m_hc[i] = nhc[i];
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    step_model();
    #1;
  endtask

  task automatic csr(input logic [11:0] a, input logic [2:0] o, input logic [31:0] d);
    wr_en = 1; addr = a; op = o; data = d; uimm = d[4:0];
  endtask

  logic [11:0] pool [28];
  logic [2:0]  ops [6];

  initial begin
    pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
             12'hF14, 12'hC01, 12'hC81, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03,
             12'hB83, 12'hB05, 12'hB85, 12'hB07, 12'h323, 12'h324, 12'h325, 12'h327,
             12'h7C0, 12'hB01, 12'h320, 12'hC00};
    ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    rst = 1; wr_en = 0; addr = 0; op = 0; uimm = 0; data = 0; pc = 0;
    eirq = 0; tirq = 0; sirq = 0; rc = 0; trap = 0; ioe = 0; cause = 0;
    mret = 0; inst = 0; evt = 0;
    model_reset();
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_trap_addr", taddr, 32'h0000_1000);
    chk("rst_mie", {31'b0, mie_o}, 32'h0);

    csr(12'h340, 3'b001, 32'hDEAD_BEEF);
    #1 chk("mscratch_old", rdata, 32'h0);
    tick();
    wr_en = 0;
    #1 chk("mscratch_new", rdata, 32'hDEAD_BEEF);
    tick();

    csr(12'h300, 3'b110, 32'd8);
    tick();
    wr_en = 0;
    #1 chk("mie_set", {31'b0, mie_o}, 32'h1);
    trap = 1; pc = 32'h100; ioe = 1; cause = 4'd7;
    tick();
    trap = 0; addr = 12'h342;
    #1 chk("trap_epc", epc, 32'h100);
    chk("trap_mcause", rdata, 32'h8000_0007);
    chk("trap_mie", {31'b0, mie_o}, 32'h0);
    addr = 12'h300;
    #1 chk("trap_mstatus", rdata, 32'h0000_1880);
    mret = 1;
    tick();
    mret = 0;
    #1 chk("mret_mie", {31'b0, mie_o}, 32'h1);
    ioe = 0; cause = 0;

    csr(12'hB00, 3'b001, 32'hFFFF_FFFF);
    tick();
    csr(12'hB80, 3'b001, 32'h0);
    tick();
    wr_en = 0;
    #1 chk("mcycleh_before", rdata, 32'h0);
    tick();
    chk("mcycleh_wrap", rdata, 32'h1);
    addr = 12'hB00;
    #1 chk("mcycle_wrap", rdata, 32'h0);

    csr(12'h323, 3'b001, 32'd2);
    tick();
    csr(12'h324, 3'b001, 32'd200);
    tick();
    wr_en = 0;
    for (int k = 0; k < 5; k++) begin
      evt = 8'h04; tick();
      evt = 8'h00; tick();
    end
    for (int k = 0; k < 3; k++) begin
      evt = 8'hFB; tick();
    end
    evt = 0; addr = 12'hB03;
    #1 chk("hpm3_count", rdata, 32'd5);
    addr = 12'hB04;
    #1 chk("hpm4_never", rdata, 32'd0);
    tick();

    csr(12'h7C0, 3'b001, 32'h1234);
    #1 chk("illegal_7c0", {31'b0, illegal}, 32'h1);
    tick();
    csr(12'hF14, 3'b001, 32'h1);
    #1 chk("illegal_hartid_rw", {31'b0, illegal}, 32'h1);
    tick();
    csr(12'hF14, 3'b010, 32'h0);
    #1 chk("hartid_rs0_legal", {31'b0, illegal}, 32'h0);
    chk("hartid_val", rdata, HARTID);
    tick();

    csr(12'h305, 3'b001, 32'h201);
    tick();
    wr_en = 0; ioe = 1; cause = 4'd11;
`ifdef MTVEC_VECTORED_EN
    #1 chk("vec_irq", taddr, 32'h22C);
    chk("mtvec_rd", rdata, 32'h201);
`else
    #1 chk("direct_irq", taddr, 32'h200);
    chk("mtvec_rd", rdata, 32'h200);
`endif
    ioe = 0; cause = 4'd2;
    #1 chk("exc_base", taddr, 32'h200);
    tick();

    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      wr_en = ($urandom_range(0, 9) < 7);
      addr  = pool[$urandom_range(0, 27)];
      op    = ops[$urandom_range(0, 5)];
      data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      uimm  = 5'($urandom_range(0, 31));
      pc    = $urandom;
      {eirq, tirq, sirq} = 3'($urandom_range(0, 7));
      rc    = {$urandom, $urandom};
      trap  = ($urandom_range(0, 15) == 0);
      mret  = ($urandom_range(0, 15) == 0);
      ioe   = 1'($urandom_range(0, 1));
      cause = 4'($urandom_range(0, 15));
      inst  = 1'($urandom_range(0, 1));
      evt   = 8'($urandom);
      tick();
    end

    csr(12'h340, 3'b001, 32'h5555_AAAA);
    rst = 1; trap = 1; mret = 0; eirq = 1;
    tick();
    rst = 0; wr_en = 0; trap = 0; eirq = 0; ioe = 0;
    #1 chk("midrst_scratch", rdata, 32'h0);
    chk("midrst_epc", epc, 32'h0);
    chk("midrst_trap_addr", taddr, 32'h0000_1000);
    chk("midrst_bits", {25'b0, mie_o, meie_o, mtie_o, msie_o, meip_o, mtip_o, msip_o}, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
